// File: rtl/fetch_controller.sv
`timescale 1ns/1ps
// fetch_controller
// ----------------
// Sequences a synchronous-read instruction memory (fixed 1-cycle latency, no
// read enable). It generates word-aligned fetch addresses, tags each returned
// word with its PC and hands it to decode over a valid/ready handshake.
// Because the memory cannot be stalled, a 1-entry skid buffer absorbs decode
// backpressure. Redirects from execute issue their target the same cycle.
//
// Operating states are implied by the registers rather than encoded:
//   IDLE   : no word in flight, skid empty
//   STREAM : rsp_valid (word arriving from memory this cycle)
//   HELD   : skid_valid (word parked in the skid buffer)
//
// Ports:
//   clk            system clock, all state updates on posedge
//   rst_n          asynchronous active-low reset
//   fetch_en       1 = new fetches may be issued
//   redirect_valid single-cycle redirect request (highest priority)
//   redirect_pc    redirect target byte address (aligned down internally)
//   imem_addr      combinational address to the instruction memory
//   imem_rdata     registered read data, valid 1 cycle after the address
//   if_valid       instruction word presented to decode
//   if_ready       decode accepts when if_valid && if_ready
//   if_instr       instruction word (0 when if_valid=0)
//   if_pc          byte PC of if_instr (0 when if_valid=0)
//   misalign_err   one-cycle pulse after a redirect with redirect_pc[1:0]!=0

module fetch_controller #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  misalign_err
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic                  skid_valid;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic [DATA_WIDTH-1:0] skid_instr;

  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  stall;
  logic                  issue;
  logic                  skid_fill;
  logic                  skid_drain;

  assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // A redirect overrides the sequential address so its target is issued
  // with no bubble.
  assign imem_addr = redirect_valid ? redirect_aligned : fetch_pc;

  // Output mux: the skid, when occupied, is always older than anything the
  // memory could be returning, so it has priority. A redirect squashes
  // whatever would have been presented this cycle.
  always_comb begin
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    if (!redirect_valid) begin
      if (skid_valid) begin
        if_valid = 1'b1;
        if_instr = skid_instr;
        if_pc    = skid_pc;
      end else if (rsp_valid) begin
        if_valid = 1'b1;
        if_instr = imem_rdata;
        if_pc    = rsp_pc;
      end
    end
  end

  assign stall = if_valid && !if_ready;

  // Issue is blocked while decode stalls; this guarantees the skid only ever
  // fills when nothing new is in flight behind it.
  assign issue = fetch_en && (redirect_valid || !stall);

  assign skid_fill  = rsp_valid && !skid_valid && !if_ready && !redirect_valid;
  assign skid_drain = skid_valid && if_ready;

  // Fetch address and in-flight word tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      rsp_valid <= 1'b0;
      rsp_pc    <= '0;
    end else begin
      rsp_valid <= issue;
      if (issue) begin
        rsp_pc   <= imem_addr;
        fetch_pc <= imem_addr + PC_STEP;
      end else if (redirect_valid) begin
        // Redirect while halted: remember the target for when fetch resumes.
        fetch_pc <= redirect_aligned;
      end
    end
  end

  // Skid buffer: catches the memory's word when decode refuses it, since the
  // memory output is only valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (redirect_valid) begin
      skid_valid <= 1'b0;
    end else if (skid_fill) begin
      skid_valid <= 1'b1;
      skid_pc    <= rsp_pc;
      skid_instr <= imem_rdata;
    end else if (skid_drain) begin
      skid_valid <= 1'b0;
    end
  end

  // Misalignment flag is registered so it appears the cycle after the
  // offending redirect and lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
// tb_fetch_controller
// -------------------
// Drives fetch_controller against a behavioural instruction memory whose word
// at byte address A is 32'h1000_0000 + A/4. Directed vectors cover streaming,
// backpressure, redirects, misalignment, wrap and fetch_en gaps; a hand-written
// sequence covers reset mid-stall; a random phase is checked against a
// single-slot reference model of the fetch stream.

module tb_fetch_controller;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk            = 1'b0;
  logic          rst_n          = 1'b0;
  logic          fetch_en       = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc    = '0;
  logic          if_ready       = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata     = '0;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: at most one undelivered word exists at a time (either
  // just returned by memory or parked), so it is kept as one optional slot.
  bit            m_pend;
  logic [AW-1:0] m_pend_pc;
  logic [AW-1:0] m_next_pc;
  bit            m_mis;

  typedef struct packed {
    logic          fe;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
    logic          emis;
  } vec_t;

  vec_t vecs [22];

  fetch_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with 1-cycle latency.
  always @(posedge clk) imem_rdata <= word_at(imem_addr);

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'h1000_0000 + {18'b0, a[AW-1:2]};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [AW-1:0] epc,
                             input logic [AW-1:0] eaddr, input logic emis);
    logic [DW-1:0] einstr;
    einstr = ev ? word_at(epc) : '0;
    cmp({name, "_valid"}, 32'(if_valid), 32'(ev));
    cmp({name, "_pc"}, 32'(if_pc), 32'(epc));
    cmp({name, "_instr"}, if_instr, einstr);
    cmp({name, "_addr"}, 32'(imem_addr), 32'(eaddr));
    cmp({name, "_mis"}, 32'(misalign_err), 32'(emis));
    cmp({name, "_inv"}, 32'(dut.skid_valid && dut.rsp_valid), 32'd0);
  endtask

  task automatic applyStimulus(input logic fe, input logic rv, input logic [AW-1:0] rpc,
                               input logic rdy);
    @(negedge clk);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    #2;
  endtask

  task automatic modelReset();
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_next_pc = 16'h0000;
    m_mis     = 1'b0;
  endtask

  task automatic modelExpect(output logic ev, output logic [AW-1:0] epc,
                             output logic [AW-1:0] eaddr, output logic emis);
    logic [AW-1:0] tgt;
    tgt   = redirect_pc & ~16'd3;
    ev    = m_pend && !redirect_valid;
    epc   = ev ? m_pend_pc : '0;
    eaddr = redirect_valid ? tgt : m_next_pc;
    emis  = m_mis;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    logic          shown;
    logic          held;
    logic [AW-1:0] tgt;
    shown = m_pend && !redirect_valid;
    held  = shown && !if_ready;
    tgt   = redirect_pc & ~16'd3;
    m_mis = redirect_valid && (redirect_pc % 4 != 0);
    if (redirect_valid) begin
      m_pend    = fetch_en;
      m_pend_pc = tgt;
      m_next_pc = fetch_en ? AW'(tgt + 4) : tgt;
    end else if (held) begin
      m_pend = 1'b1;
    end else if (fetch_en) begin
      m_pend    = 1'b1;
      m_pend_pc = m_next_pc;
      m_next_pc = AW'(m_next_pc + 4);
    end else begin
      m_pend = 1'b0;
    end
  endtask

  task automatic modelCycle(input string name);
    logic          ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
    logic          emis;
    modelExpect(ev, epc, eaddr, emis);
    checkOutput(name, ev, epc, eaddr, emis);
    modelStep();
  endtask

  initial begin
    //            fe    rv    rpc       rdy   ev    epc       eaddr     emis
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0008, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h000C, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h000C, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 16'h0010, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0104, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0104, 16'h0108, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0104, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0104, 16'h0108, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 16'hFFFC, 1'b1, 1'b0, 16'h0000, 16'hFFFC, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFC, 16'h0000, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'h0008, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'h000C, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000C, 16'h0010, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000C, 16'h0010, 1'b0};

    // Reset state.
    modelReset();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eaddr, vecs[i].emis);
      modelStep();
    end

    // Reset asserted while a word is held in the skid: outputs clear at once.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid", 1'b0, 16'h0000, 16'h0000, 1'b0);
    modelReset();
    fetch_en = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from RESET_PC, then a redirect while halted.
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("rs0", 1'b0, 16'h0000, 16'h0000, 1'b0);
    modelStep();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("rs1", 1'b1, 16'h0000, 16'h0004, 1'b0);
    modelStep();
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b1);
    checkOutput("rs2", 1'b0, 16'h0000, 16'h0200, 1'b0);
    modelStep();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("rs3", 1'b0, 16'h0000, 16'h0200, 1'b0);
    modelStep();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("rs4", 1'b0, 16'h0000, 16'h0200, 1'b0);
    modelStep();
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("rs5", 1'b1, 16'h0200, 16'h0204, 1'b0);
    modelStep();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 9) == 0),
                    16'($urandom),
                    1'($urandom_range(0, 9) < 7));
      modelCycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the synchronous-read instruction memory: generates word-aligned fetch addresses, tags each returned word with its PC and delivers it to decode over a valid/ready handshake.
- The memory has a fixed 1-cycle read latency and no enable, so the block holds a 1-entry skid buffer to absorb decode backpressure without losing data.
- Accepts redirects (branch/jump/trap targets) from execute with zero-bubble issue of the target address.
- Sits between the PC-redirect logic and instruction_memory, feeding the decode stage.

Parameters:
- ADDR_WIDTH, 16, byte-address width of the instruction memory.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 16'h0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  1 = new fetches may be issued; 0 = halt issue, in-flight word still delivered.
- redirect_valid  input  1  single-cycle redirect request.
- redirect_pc  input  ADDR_WIDTH  redirect target byte address.
- imem_addr  output  ADDR_WIDTH  address to instruction memory, combinational.
- imem_rdata  input  DATA_WIDTH  registered read data from memory, valid 1 cycle after address.
- if_valid  output  1  instruction word presented to decode.
- if_ready  input  1  decode accepts when if_valid && if_ready.
- if_instr  output  DATA_WIDTH  instruction word.
- if_pc  output  ADDR_WIDTH  byte PC of if_instr.
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- State registers:
  - fetch_pc: next address to issue.
  - rsp_valid / rsp_pc: word in flight from the memory.
  - skid_valid / skid_pc / skid_instr: 1-entry skid buffer.
- Reset (async, rst_n=0): fetch_pc=RESET_PC; rsp_valid=0; skid_valid=0; misalign_err=0. Consequently if_valid=0, if_instr=0, if_pc=0.
- Address mux: imem_addr = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2],2'b00} : fetch_pc. Bits [1:0] of imem_addr are always 0.
- Output mux:
  - skid_valid=1: present skid_instr / skid_pc.
  - Otherwise: present imem_rdata / rsp_pc, with if_valid = rsp_valid.
  - if_valid is forced 0 in any cycle with redirect_valid=1.
  - When if_valid=0, if_instr and if_pc are 0.
- stall = if_valid && !if_ready.
- Issue: issue = fetch_en && (redirect_valid || !stall). On issue at posedge:
  - rsp_valid<=1; rsp_pc<=imem_addr; fetch_pc<=imem_addr+4, modulo 2^ADDR_WIDTH (16'hFFFC wraps to 16'h0000).
  - No issue: rsp_valid<=0; fetch_pc holds, except on redirect.
- Skid fill: rsp_valid && !skid_valid && !if_ready && !redirect_valid captures imem_rdata and rsp_pc into the skid (skid_valid<=1). No issue occurs that cycle, so the skid never coexists with an in-flight word.
- Skid drain: skid_valid && if_ready clears skid_valid. An issue is permitted in the same cycle.
- Invariant: skid_valid && rsp_valid never both 1. The bench asserts this.
- Redirect (has priority over everything):
  - Discards the in-flight word and the skid (both cleared).
  - Issues the target this cycle if fetch_en=1, in which case its word appears as if_valid next cycle.
  - If fetch_en=0, fetch_pc<=aligned target and nothing is issued.
- Misaligned redirect: target is aligned down; misalign_err=1 for the following cycle only.
- Operating states (derived, not encoded):
  - IDLE (no rsp, no skid).
  - STREAM (rsp_valid).
  - HELD (skid_valid).
  - Transitions:
    - IDLE→STREAM on issue.
    - STREAM→STREAM on accept+issue.
    - STREAM→HELD on stall.
    - HELD→STREAM on drain with issue.
    - HELD→IDLE on drain without fetch_en.
    - Any state→STREAM/IDLE on redirect.
- fetch_en deassert mid-stream: the in-flight word is still delivered, or skid-held if stalled; nothing new is issued.
- Throughput: 1 instruction/cycle with if_ready held high.
- Latency: 1 cycle from issue to if_valid; first if_valid is the 2nd posedge after rst_n rises, with fetch_en=1.
- Reset mid-operation clears everything immediately, including if_valid.

Test Plan:
- Reset release, fetch_en=1, if_ready=1, memory word k = 32'h1000_0000+k → if_pc sequence 0x0000,0x0004,0x0008, each with matching instr, one per cycle, first one cycle after first issue.
- Backpressure: drop if_ready for 3 cycles while if_pc=0x0008 is presented → if_valid stays 1 with 0x0008 held (from skid) and no duplicates or gaps; on release, 0x0008 is accepted, 0x000C appears the next cycle.
- Redirect to 0x0100 while streaming and while in HELD → if_valid=0 that cycle; next cycle if_pc=0x0100; old words never delivered; skid cleared.
- Redirect to 0x0102 → misalign_err pulses once; next if_pc=0x0100.
- Wrap: redirect to 0xFFFC → if_pc 0xFFFC then 0x0000.
- fetch_en dropped for one cycle mid-stream, and rst_n asserted mid-stall → one-cycle bubble with no lost or duplicated PC; on reset, if_valid=0 immediately and restart from RESET_PC.
